// File: rtl/planificador_compuerta_if.sv
// Handshake bundle between the parking gate scheduler and its surroundings:
// lane sensors and password result in, arm command and lot status out.
interface planificador_compuerta_if #(
  parameter int CNT_W = 4
);
  logic             req_entrada;
  logic             pass_ok;
  logic             req_salida;
  logic             paso;
  logic             abrir;
  logic             sel_salida;
  logic [CNT_W-1:0] ocupacion;
  logic             lleno;
  logic             alarma;

  modport master (
    output req_entrada, pass_ok, req_salida, paso,
    input  abrir, sel_salida, ocupacion, lleno, alarma
  );

  modport slave (
    input  req_entrada, pass_ok, req_salida, paso,
    output abrir, sel_salida, ocupacion, lleno, alarma
  );
endinterface

// File: rtl/planificador_compuerta.sv
// Round-robin scheduler for the shared gate arm: entry needs a password,
// exit opens directly; tracks lot occupancy and flags clearance timeouts.
module planificador_compuerta #(
  parameter int CAPACIDAD = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  planificador_compuerta_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ESPERA_CLAVE, ABIERTA, ALARMA} estado_t;

  estado_t          r_estado;
  logic             r_abrir;
  logic             r_sel_salida;
  logic             r_alarma;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_ocupacion;
  logic [TW-1:0]    r_timer;

  logic             w_lleno;
  logic             w_ent_ok;
  logic             w_sal_ok;
  logic             w_pick_ent;
  logic             w_expira;
  logic [CNT_W-1:0] w_ocup_paso;

  assign w_lleno    = (r_ocupacion == CNT_W'(CAPACIDAD));
  assign w_ent_ok   = bus.req_entrada & ~w_lleno;
  assign w_sal_ok   = bus.req_salida;
  // On a tie the lane that did not get the last grant wins.
  assign w_pick_ent = w_ent_ok & (~w_sal_ok | r_last_grant);
  assign w_expira   = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_ocup_paso = r_ocupacion;
    if (!r_sel_salida)
      w_ocup_paso = r_ocupacion + CNT_W'(1);
    else if (r_ocupacion != '0)
      w_ocup_paso = r_ocupacion - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado     <= IDLE;
      r_abrir      <= 1'b0;
      r_sel_salida <= 1'b0;
      r_alarma     <= 1'b0;
      r_last_grant <= 1'b1;
      r_ocupacion  <= '0;
      r_timer      <= '0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (w_pick_ent) begin
            r_estado     <= ESPERA_CLAVE;
            r_sel_salida <= 1'b0;
            r_last_grant <= 1'b0;
            r_timer      <= '0;
          end else if (w_sal_ok) begin
            r_estado     <= ABIERTA;
            r_sel_salida <= 1'b1;
            r_abrir      <= 1'b1;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
          end
        end
        ESPERA_CLAVE: begin
          if (bus.pass_ok) begin
            r_estado <= ABIERTA;
            r_abrir  <= 1'b1;
            r_timer  <= '0;
          end else if (!bus.req_entrada || w_expira) begin
            r_estado <= IDLE;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ABIERTA: begin
          if (bus.paso) begin
            r_estado    <= IDLE;
            r_abrir     <= 1'b0;
            r_ocupacion <= w_ocup_paso;
            r_timer     <= '0;
          end else if (w_expira) begin
            r_estado <= ALARMA;
            r_alarma <= 1'b1;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ALARMA: begin
          // The arm stays up until the car is confirmed clear.
          if (bus.paso) begin
            r_estado    <= IDLE;
            r_abrir     <= 1'b0;
            r_alarma    <= 1'b0;
            r_ocupacion <= w_ocup_paso;
            r_timer     <= '0;
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign bus.abrir      = r_abrir;
  assign bus.sel_salida = r_sel_salida;
  assign bus.alarma     = r_alarma;
  assign bus.ocupacion  = r_ocupacion;
  assign bus.lleno      = w_lleno;
endmodule

// File: tb/tb_planificador_compuerta.sv
// Randomized scoreboard bench for planificador_compuerta: a transaction-level
// model predicts the outputs after every edge; a monitor compares them.
module tb_planificador_compuerta;
  localparam int CAP = 8;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  planificador_compuerta_if #(.CNT_W(4)) bus ();

  planificador_compuerta #(.CAPACIDAD(CAP), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       abrir;
    logic       sel_salida;
    logic [3:0] ocupacion;
    logic       lleno;
    logic       alarma;
  } salida_t;

  salida_t sb_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: a grant record plus a car count.
  bit m_grant_active;
  bit m_exit_lane;
  bit m_arm_up;
  bit m_alarm;
  bit m_last_was_exit;
  int m_elapsed;
  int m_cars;

  function automatic salida_t expected();
    salida_t e;
    e.abrir      = m_arm_up;
    e.sel_salida = m_exit_lane;
    e.ocupacion  = 4'(m_cars);
    e.lleno      = (m_cars == CAP);
    e.alarma     = m_alarm;
    return e;
  endfunction

  task automatic model_step(bit rst, bit re, bit po, bit rs, bit pa);
    if (rst) begin
      m_grant_active = 0; m_exit_lane = 0; m_arm_up = 0; m_alarm = 0;
      m_last_was_exit = 1; m_elapsed = 0; m_cars = 0;
    end else if (!m_grant_active) begin
      bit want_in, want_out;
      want_in  = re && (m_cars < CAP);
      want_out = rs;
      if (want_in && (!want_out || m_last_was_exit)) begin
        m_grant_active = 1; m_exit_lane = 0; m_last_was_exit = 0; m_elapsed = 0;
      end else if (want_out) begin
        m_grant_active = 1; m_exit_lane = 1; m_arm_up = 1;
        m_last_was_exit = 1; m_elapsed = 0;
      end
    end else if (!m_arm_up) begin
      if (po) begin
        m_arm_up = 1; m_elapsed = 0;
      end else if (!re || m_elapsed == TMO - 1) begin
        m_grant_active = 0;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (pa) begin
        if (!m_exit_lane) m_cars++;
        else if (m_cars > 0) m_cars--;
        m_grant_active = 0; m_arm_up = 0; m_alarm = 0;
      end else if (!m_alarm) begin
        if (m_elapsed == TMO - 1) m_alarm = 1;
        else m_elapsed++;
      end
    end
  endtask

  task automatic cyc(bit rst, bit re, bit po, bit rs, bit pa);
    @(negedge clock);
    reset           = rst;
    bus.req_entrada = re;
    bus.pass_ok     = po;
    bus.req_salida  = rs;
    bus.paso        = pa;
    model_step(rst, re, po, rs, pa);
    sb_q.push_back(expected());
  endtask

  function automatic bit pct(int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic run(int n, int pre, int ppo, int prs, int ppa, int prst);
    for (int i = 0; i < n; i++)
      cyc(pct(prst), pct(pre), pct(ppo), pct(prs), pct(ppa));
  endtask

  // Monitor: every edge the DUT presents a fresh output set.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        salida_t e, a;
        e = sb_q.pop_front();
        a = '{bus.abrir, bus.sel_salida, bus.ocupacion, bus.lleno, bus.alarma};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got abrir=%b sel=%b ocup=%0d lleno=%b alarma=%b want abrir=%b sel=%b ocup=%0d lleno=%b alarma=%b",
                   $time, a.abrir, a.sel_salida, a.ocupacion, a.lleno, a.alarma,
                   e.abrir, e.sel_salida, e.ocupacion, e.lleno, e.alarma);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.req_entrada = 0; bus.pass_ok = 0; bus.req_salida = 0; bus.paso = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // Entry: pass_ok 3 cycles after request, paso 5 cycles later.
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // Both lanes held with immediate pass_ok/paso: alternating grants.
    repeat (12) cyc(0, 1, 1, 1, 1);
    // Entry abandoned by timeout, then exit held into alarm and cleared.
    repeat (20) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    // Fill the lot to capacity, then contend with exit while full.
    repeat (40) cyc(0, 1, 1, 0, 1);
    repeat (6) cyc(0, 1, 1, 1, 1);
    // Reset while arm is up, then exit at zero occupancy.
    repeat (6) cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    // Randomized phases: entry-heavy, balanced, sparse handshakes, resets.
    run(800, 85, 50, 15, 50, 0);
    run(1500, 50, 30, 50, 30, 0);
    run(1500, 60, 5, 40, 4, 0);
    run(1500, 50, 25, 50, 25, 1);
    @(posedge clock);
    #3;
    @(posedge clock);
    #3;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
